// File: rtl/wb2axi4l_pkg.sv
// Shared types for the Wishbone-to-AXI4-Lite bridge: FSM states and AXI response codes.
// No logic and no latency; the package holds only definitions.
package wb2axi4l_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WRESP,
      ST_READ,
      ST_RRESP,
      ST_TERM,
      ST_DRAIN
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/wb2axi4l_bridge.sv
// Wishbone classic slave to AXI4-Lite master, one transaction in flight; 3-cycle request-to-ack with a zero-wait slave.
// Wishbone is stalled (no ack) until the AXI response returns; a watchdog converts a hung slave into wb_err_o.
module wb2axi4l_bridge
   import wb2axi4l_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                    wb_we_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_cyc_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
   logic [STRB_W-1:0]       sel_q, sel_d;
   logic                    we_q, we_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    abandoned_q, abandoned_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;

   logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic             wb_req, abn, expire;
   logic [CNT_W-1:0] cnt_inc;

   assign aw_hs = awvalid_q & m_axi_awready;
   assign w_hs  = wvalid_q & m_axi_wready;
   assign b_hs  = bready_q & m_axi_bvalid;
   assign ar_hs = arvalid_q & m_axi_arready;
   assign r_hs  = rready_q & m_axi_rvalid;

   assign wb_req  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
   // A master that has let go of the cycle gets no termination, even in the dropping cycle.
   assign abn     = abandoned_q | ~wb_cyc_i;
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX);

   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      sel_d       = sel_q;
      we_d        = we_q;
      awvalid_d   = awvalid_q & ~aw_hs;
      wvalid_d    = wvalid_q & ~w_hs;
      arvalid_d   = arvalid_q & ~ar_hs;
      bready_d    = bready_q & ~b_hs;
      rready_d    = rready_q & ~r_hs;
      aw_done_d   = aw_done_q | aw_hs;
      w_done_d    = w_done_q | w_hs;
      abandoned_d = abandoned_q;
      cnt_d       = (state_q == ST_IDLE || state_q == ST_TERM) ? cnt_q : cnt_inc;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      rdat_d      = rdat_q;

      if ((state_q inside {ST_WRITE, ST_WRESP, ST_READ, ST_RRESP}) && !wb_cyc_i)
         abandoned_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (wb_req) begin
               adr_d       = wb_adr_i;
               wdat_d      = wb_dat_i;
               sel_d       = wb_sel_i;
               we_d        = wb_we_i;
               cnt_d       = '0;
               abandoned_d = 1'b0;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               if (wb_we_i) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WRITE;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_READ;
               end
            end
         end
         ST_WRITE: begin
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = ST_WRESP;
            end else if (expire) begin
               err_d   = ~abn;
               state_d = ST_DRAIN;
            end
         end
         ST_WRESP: begin
            // A response in the expiry cycle still terminates normally.
            if (b_hs) begin
               ack_d   = ~abn & ~resp_is_err(m_axi_bresp);
               err_d   = ~abn & resp_is_err(m_axi_bresp);
               state_d = ST_TERM;
            end else if (expire) begin
               err_d   = ~abn;
               state_d = ST_DRAIN;
            end
         end
         ST_READ: begin
            if (ar_hs) begin
               rready_d = 1'b1;
               state_d  = ST_RRESP;
            end else if (expire) begin
               err_d   = ~abn;
               state_d = ST_DRAIN;
            end
         end
         ST_RRESP: begin
            if (r_hs) begin
               rdat_d  = m_axi_rdata;
               ack_d   = ~abn & ~resp_is_err(m_axi_rresp);
               err_d   = ~abn & resp_is_err(m_axi_rresp);
               state_d = ST_TERM;
            end else if (expire) begin
               err_d   = ~abn;
               state_d = ST_DRAIN;
            end
         end
         ST_TERM: begin
            state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            // The Wishbone side is already terminated; just finish the AXI handshakes silently.
            if (we_q) begin
               if (b_hs)
                  state_d = ST_IDLE;
               else if (aw_done_d && w_done_d)
                  bready_d = 1'b1;
            end else begin
               if (r_hs)
                  state_d = ST_IDLE;
               else if (!arvalid_d)
                  rready_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         adr_q       <= '0;
         wdat_q      <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         abandoned_q <= 1'b0;
         cnt_q       <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         rdat_q      <= '0;
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         wdat_q      <= wdat_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         abandoned_q <= abandoned_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdat_q      <= rdat_d;
      end
   end

   assign wb_dat_o      = rdat_q;
   assign wb_ack_o      = ack_q;
   assign wb_err_o      = err_q;
   assign m_axi_awaddr  = adr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdat_q;
   assign m_axi_wstrb   = sel_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = adr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_wb2axi4l_bridge.sv
// Scoreboarded bench for wb2axi4l_bridge: directed Wishbone transfers against a configurable AXI4-Lite slave.
module tb_wb2axi4l_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-1:0] wb_adr_i;
   logic [DW-1:0] wb_dat_i;
   logic [3:0]    wb_sel_i;
   logic          wb_we_i, wb_stb_i, wb_cyc_i;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o, wb_err_o;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]    m_axi_awprot, m_axi_arprot;
   logic          m_axi_awvalid, m_axi_awready;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [3:0]    m_axi_wstrb;
   logic          m_axi_wvalid, m_axi_wready;
   logic [1:0]    m_axi_bresp, m_axi_rresp;
   logic          m_axi_bvalid, m_axi_bready;
   logic          m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;

   wb2axi4l_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
      .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_err;
      logic        chk_dat;
      logic [31:0] dat;
   } term_t;

   typedef struct {
      logic [31:0] dat;
      logic [3:0]  strb;
   } wexp_t;

   logic [31:0] exp_aw[$];
   logic [31:0] exp_ar[$];
   wexp_t       exp_w[$];
   term_t       exp_term[$];

   // Slave behaviour knobs; delays are cycles from valid seen to ready/response driven.
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   logic [31:0] r_data_cfg = '0;
   int          r_fires = 0;

   // AXI4-Lite slave model: handshakes sampled at negedge, drives updated just after posedge.
   initial begin
      logic aw_f, w_f, b_f, ar_f, r_f;
      logic aw_got, w_got, ar_got;
      int   aw_wait, w_wait, b_wait, ar_wait, r_wait;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      forever begin
         @(negedge clk);
         aw_f = m_axi_awvalid & m_axi_awready;
         w_f  = m_axi_wvalid & m_axi_wready;
         b_f  = m_axi_bvalid & m_axi_bready;
         ar_f = m_axi_arvalid & m_axi_arready;
         r_f  = m_axi_rvalid & m_axi_rready;
         @(posedge clk);
         #1;
         if (rst) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
         end else begin
            if (aw_f) begin aw_got = 1; m_axi_awready = 0; aw_wait = 0; end
            else if (m_axi_awvalid) begin
               if (aw_wait >= aw_delay) m_axi_awready = 1; else aw_wait++;
            end
            if (w_f) begin w_got = 1; m_axi_wready = 0; w_wait = 0; end
            else if (m_axi_wvalid) begin
               if (w_wait >= w_delay) m_axi_wready = 1; else w_wait++;
            end
            if (b_f) begin m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; end
            else if (aw_got && w_got && !m_axi_bvalid) begin
               if (b_wait >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; end
               else b_wait++;
            end
            if (ar_f) begin ar_got = 1; m_axi_arready = 0; ar_wait = 0; end
            else if (m_axi_arvalid) begin
               if (ar_wait >= ar_delay) m_axi_arready = 1; else ar_wait++;
            end
            if (r_f) begin m_axi_rvalid = 0; ar_got = 0; r_wait = 0; r_fires++; end
            else if (ar_got && !m_axi_rvalid) begin
               if (r_wait >= r_delay) begin
                  m_axi_rvalid = 1; m_axi_rdata = r_data_cfg; m_axi_rresp = r_resp_cfg;
               end else r_wait++;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every AXI request handshake and every Wishbone termination.
   initial begin
      logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
      logic [31:0] p_awa, p_wd, p_ara;
      wexp_t       we_exp;
      term_t       te;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      p_awa = 0; p_wd = 0; p_ara = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (p_awv && !p_awr) begin
               check("awvalid_hold", m_axi_awvalid, 1);
               check("awaddr_stable", m_axi_awaddr, p_awa);
            end
            if (p_wv && !p_wr) begin
               check("wvalid_hold", m_axi_wvalid, 1);
               check("wdata_stable", m_axi_wdata, p_wd);
            end
            if (p_arv && !p_arr) begin
               check("arvalid_hold", m_axi_arvalid, 1);
               check("araddr_stable", m_axi_araddr, p_ara);
            end
            if (m_axi_awvalid && m_axi_awready) begin
               if (exp_aw.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL aw_unexpected: got AW addr 0x%h, required no AW", m_axi_awaddr);
               end else begin
                  check("awaddr", m_axi_awaddr, exp_aw.pop_front());
                  check("awprot", m_axi_awprot, 0);
               end
            end
            if (m_axi_wvalid && m_axi_wready) begin
               if (exp_w.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL w_unexpected: got W data 0x%h, required no W", m_axi_wdata);
               end else begin
                  we_exp = exp_w.pop_front();
                  check("wdata", m_axi_wdata, we_exp.dat);
                  check("wstrb", m_axi_wstrb, we_exp.strb);
               end
            end
            if (m_axi_arvalid && m_axi_arready) begin
               if (exp_ar.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL ar_unexpected: got AR addr 0x%h, required no AR", m_axi_araddr);
               end else begin
                  check("araddr", m_axi_araddr, exp_ar.pop_front());
                  check("arprot", m_axi_arprot, 0);
               end
            end
            if (wb_ack_o && wb_err_o) begin
               checks++; errors++;
               $display("FAIL ack_and_err: got both high, required at most one");
            end
            if (wb_ack_o || wb_err_o) begin
               if (exp_term.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL term_unexpected: got ack=%0b err=%0b, required none", wb_ack_o, wb_err_o);
               end else begin
                  te = exp_term.pop_front();
                  check("term_is_err", wb_err_o, te.is_err);
                  if (te.chk_dat) check("rdata", wb_dat_o, te.dat);
               end
            end
         end
         p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awa = m_axi_awaddr;
         p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wd  = m_axi_wdata;
         p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_ara = m_axi_araddr;
      end
   end

   // lat counts negedges until termination: a zero-wait slave gives 3.
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int drop_after, input bit keep,
                          output int lat);
      bit done;
      @(posedge clk);
      #1;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      lat = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) done = 1;
         else begin
            lat++;
            if (drop_after > 0 && lat == drop_after) done = 1;
            else if (lat > 100) begin
               checks++; errors++;
               $display("FAIL xfer_timeout: no termination after %0d cycles, required one", lat);
               done = 1;
            end
         end
      end
      if (!keep) begin
         @(posedge clk);
         #1;
         wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      end
   endtask

   task automatic push_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic is_err);
      wexp_t w;
      term_t t;
      w.dat = dat; w.strb = sel;
      t.is_err = is_err; t.chk_dat = 0; t.dat = 0;
      exp_aw.push_back(adr);
      exp_w.push_back(w);
      exp_term.push_back(t);
   endtask

   task automatic push_read(input logic [31:0] adr, input logic [31:0] dat, input logic is_err);
      term_t t;
      t.is_err = is_err; t.chk_dat = 1; t.dat = dat;
      exp_ar.push_back(adr);
      exp_term.push_back(t);
   endtask

   task automatic ack_gone(input string name);
      @(negedge clk);
      check(name, {wb_ack_o, wb_err_o}, 2'b00);
   endtask

   task automatic slave_cfg(input int awd, input int wd, input int ard, input int rd,
                            input logic [1:0] bresp, input logic [1:0] rresp, input logic [31:0] rdata);
      @(negedge clk);
      aw_delay = awd; w_delay = wd; b_delay = 0; ar_delay = ard; r_delay = rd;
      b_resp_cfg = bresp; r_resp_cfg = rresp; r_data_cfg = rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish, required completion");
      $fatal(1, "global timeout");
   end

   initial begin
      int lat;
      int rf;
      rst = 1;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("rst_awvalid", m_axi_awvalid, 0);
      check("rst_wvalid", m_axi_wvalid, 0);
      check("rst_arvalid", m_axi_arvalid, 0);
      check("rst_bready", m_axi_bready, 0);
      check("rst_rready", m_axi_rready, 0);
      check("rst_ack_err", {wb_ack_o, wb_err_o}, 2'b00);
      check("rst_dat", wb_dat_o, 0);

      // Zero-wait write: ack 3 cycles after the request edge, one cycle wide.
      slave_cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
      push_write(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0);
      wb_xfer(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, lat);
      check("wr_zero_wait_latency", lat, 3);
      ack_gone("wr_ack_one_cycle");

      // Read: arready 2 cycles late, rvalid 5 cycles after that -> 3+2+5.
      slave_cfg(0, 0, 2, 5, 2'b00, 2'b00, 32'h1234_5678);
      push_read(32'h1000_0014, 32'h1234_5678, 0);
      wb_xfer(0, 32'h1000_0014, 32'h0, 4'hF, 0, 0, lat);
      check("rd_delayed_latency", lat, 10);
      ack_gone("rd_ack_one_cycle");

      // wready 3 cycles after awready, SLVERR -> single err.
      slave_cfg(0, 3, 0, 0, 2'b10, 2'b00, 32'h0);
      push_write(32'h1000_0018, 32'hA5A5_0F0F, 4'hF, 1);
      wb_xfer(1, 32'h1000_0018, 32'hA5A5_0F0F, 4'hF, 0, 0, lat);
      check("wr_slverr_latency", lat, 6);
      ack_gone("wr_err_one_cycle");

      // W before AW, partial strobes, EXOKAY counts as success.
      slave_cfg(2, 0, 0, 0, 2'b01, 2'b00, 32'h0);
      push_write(32'h1000_001C, 32'h0000_BEEF, 4'h3, 0);
      wb_xfer(1, 32'h1000_001C, 32'h0000_BEEF, 4'h3, 0, 0, lat);
      check("wr_w_first_latency", lat, 5);

      // DECERR read -> err, data still captured.
      slave_cfg(0, 0, 0, 0, 2'b00, 2'b11, 32'hAAAA_5555);
      push_read(32'h1000_0024, 32'hAAAA_5555, 1);
      wb_xfer(0, 32'h1000_0024, 32'h0, 4'hF, 0, 0, lat);
      check("rd_decerr_latency", lat, 3);

      // rvalid handshake lands exactly on the watchdog expiry edge: response wins.
      slave_cfg(0, 0, 0, 14, 2'b00, 2'b00, 32'h0BAD_F00D);
      push_read(32'h1000_0028, 32'h0BAD_F00D, 0);
      wb_xfer(0, 32'h1000_0028, 32'h0, 4'hF, 0, 0, lat);
      check("rd_race_expiry_latency", lat, TO + 1);

      // Hung AR: err once counter hits 16 (17 negedges after request), then drain silently.
      slave_cfg(0, 0, 1000, 0, 2'b00, 2'b00, 32'h0);
      exp_ar.push_back(32'h1000_0020);
      exp_term.push_back('{is_err: 1'b1, chk_dat: 1'b0, dat: 32'h0});
      wb_xfer(0, 32'h1000_0020, 32'h0, 4'hF, 0, 0, lat);
      check("timeout_latency", lat, TO + 1);
      rf = r_fires;
      slave_cfg(0, 0, 0, 2, 2'b00, 2'b00, 32'h5151_5151);
      repeat (10) @(negedge clk);
      check("timeout_drained", r_fires, rf + 1);
      slave_cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
      push_write(32'h1000_0040, 32'h0000_0001, 4'hF, 0);
      wb_xfer(1, 32'h1000_0040, 32'h0000_0001, 4'hF, 0, 0, lat);
      check("after_timeout_latency", lat, 3);

      // Abandon mid-read: AXI completes, no termination, wb_dat_o still updated.
      slave_cfg(0, 0, 0, 6, 2'b00, 2'b00, 32'hCAFE_0001);
      exp_ar.push_back(32'h1000_0030);
      rf = r_fires;
      wb_xfer(0, 32'h1000_0030, 32'h0, 4'hF, 2, 0, lat);
      repeat (12) @(negedge clk);
      check("abandon_r_done", r_fires, rf + 1);
      check("abandon_dat_o", wb_dat_o, 32'hCAFE_0001);
      push_write(32'h1000_0034, 32'h7777_8888, 4'hC, 0);
      wb_xfer(1, 32'h1000_0034, 32'h7777_8888, 4'hC, 0, 0, lat);
      check("after_abandon_latency", lat, 3);

      // Back-to-back: stb stays high through the ack cycle, next request follows directly.
      slave_cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
      push_write(32'h1000_0050, 32'h1111_2222, 4'hF, 0);
      push_write(32'h1000_0054, 32'h3333_4444, 4'hF, 0);
      wb_xfer(1, 32'h1000_0050, 32'h1111_2222, 4'hF, 0, 1, lat);
      check("b2b_first_latency", lat, 3);
      wb_xfer(1, 32'h1000_0054, 32'h3333_4444, 4'hF, 0, 0, lat);
      check("b2b_second_latency", lat, 3);
      repeat (5) @(negedge clk);

      check("aw_queue_empty", exp_aw.size(), 0);
      check("w_queue_empty", exp_w.size(), 0);
      check("ar_queue_empty", exp_ar.size(), 0);
      check("term_queue_empty", exp_term.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
